// File: rtl/delay_line_arbiter.sv
// Four-requester round-robin arbiter feeding a fixed-latency delay line.
// Each granted word travels DEPTH stages tagged with its requester id.
module delay_line_arbiter #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 8,
    parameter int    DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           flush,
    input  logic [3:0]                     req,
    input  logic [4*BIT_WIDTH-1:0]         data,
    output logic [3:0]                     gnt,
    output logic                           out_valid,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic [1:0]                     out_id,
    output logic [$clog2(DEPTH+1)-1:0]     inflight
);

    localparam int CW = $clog2(DEPTH + 1);

    // Identification parameters only; kept referenced so lint stays quiet.
    logic w_unused_params;
    assign w_unused_params = (UUID != 0) || (NAME != "");

    logic [1:0]                      r_ptr      = '0;
    logic [DEPTH-1:0]                r_valid    = '0;
    logic [DEPTH-1:0][1:0]           r_id       = '0;
    logic [DEPTH-1:0][BIT_WIDTH-1:0] r_data     = '0;
    logic [CW-1:0]                   r_inflight = '0;

    logic [3:0] w_gnt;
    logic [1:0] w_gnt_idx;
    logic       w_accept;
    logic       w_arb_ok;
    logic [1:0] w_cand;

    // Scan from the pointer; first requester found wins.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_accept  = 1'b0;
        w_cand    = '0;
        w_arb_ok  = en && !flush && !rst;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (w_arb_ok && !w_accept && req[w_cand]) begin
                w_accept       = 1'b1;
                w_gnt_idx      = w_cand;
                w_gnt[w_cand]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_valid    <= '0;
            r_id       <= '0;
            r_data     <= '0;
            r_inflight <= '0;
        end else if (flush) begin
            r_valid    <= '0;
            r_id       <= '0;
            r_data     <= '0;
            r_inflight <= '0;
        end else if (en) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_id[k]    <= r_id[k-1];
                r_data[k]  <= r_data[k-1];
            end
            r_valid[0] <= w_accept;
            r_id[0]    <= w_accept ? w_gnt_idx : 2'd0;
            r_data[0]  <= w_accept ? data[w_gnt_idx*BIT_WIDTH +: BIT_WIDTH] : '0;
            if (w_accept) begin
                r_ptr <= w_gnt_idx + 2'd1;
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(r_valid[DEPTH-1]);
        end
    end

    // Outputs forced low while reset is held, even before the clearing edge.
    always_comb begin
        gnt       = w_gnt;
        out_valid = r_valid[DEPTH-1] && !rst;
        out_data  = out_valid ? r_data[DEPTH-1] : '0;
        out_id    = out_valid ? r_id[DEPTH-1] : 2'd0;
        inflight  = r_inflight;
    end

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Directed-vector bench for delay_line_arbiter (BIT_WIDTH=8, DEPTH=3).
module tb_delay_line_arbiter;

    localparam int BW = 8;
    localparam int DP = 3;

    logic          clk = 1'b0;
    logic          rst, en, flush;
    logic [3:0]    req;
    logic [4*BW-1:0] data;
    logic [3:0]    gnt;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [1:0]    out_id;
    logic [1:0]    inflight;

    int n_vec = 0;
    int n_bad = 0;

    delay_line_arbiter #(
        .UUID      (0),
        .NAME      ("dut"),
        .BIT_WIDTH (BW),
        .DEPTH     (DP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; req = 4'b1111;
        data = {8'h43, 8'h32, 8'h21, 8'h10};
        settle();
        check("rst_gnt", gnt, 4'b0000);
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_id, 0);
        check("rst_inflight", inflight, 0);

        // Single request
        rst = 1'b0; req = 4'b0001; data = {8'h00, 8'h00, 8'h00, 8'hA5};
        settle();
        check("single_gnt", gnt, 4'b0001);
        step();
        req = 4'b0000;
        check("single_if1", inflight, 1);
        step();
        check("single_if2", inflight, 1);
        check("single_nv2", out_valid, 0);
        step();
        check("single_v3", out_valid, 1);
        check("single_d3", out_data, 8'hA5);
        check("single_id3", out_id, 0);
        check("single_if3", inflight, 1);
        step();
        check("single_v4", out_valid, 0);
        check("single_d4", out_data, 0);
        check("single_if4", inflight, 0);

        // Skip idle requesters with ptr=1
        req = 4'b1001;
        settle();
        check("skip_gnt1", gnt, 4'b1000);
        step();
        settle();
        check("skip_gnt2", gnt, 4'b0001);
        step();
        req = 4'b0000;
        step();
        check("skip_out_id3", out_id, 3);
        check("skip_out_v", out_valid, 1);
        step();
        check("skip_out_id0", out_id, 0);
        step();
        check("skip_drain", inflight, 0);

        // Fairness from ptr=0 after a reset
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b1111; data = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int e = 0; e < 8; e++) begin
            settle();
            check($sformatf("fair_gnt%0d", e), gnt, 32'(4'b0001 << (e % 4)));
            step();
            check($sformatf("fair_if%0d", e), inflight, (e + 1 < 3) ? e + 1 : 3);
            if (e >= 2) begin
                check($sformatf("fair_id%0d", e), out_id, (e - 2) % 4);
                check($sformatf("fair_d%0d", e), out_data, 8'h10 + 8'h11 * 8'((e - 2) % 4));
            end
        end
        req = 4'b0000;
        step(); step(); step();
        check("fair_drain", inflight, 0);

        // Stall: ptr=0, accept 0x11 from requester 2
        req = 4'b0100; data = {8'h00, 8'h11, 8'h00, 8'h00};
        settle();
        check("stall_gnt", gnt, 4'b0100);
        step();
        req = 4'b0001; en = 1'b0;
        settle();
        check("stall_gnt_off", gnt, 4'b0000);
        step();
        check("stall_if_a", inflight, 1);
        step();
        check("stall_if_b", inflight, 1);
        check("stall_nv", out_valid, 0);
        req = 4'b0000; en = 1'b1;
        step();
        check("stall_nv4", out_valid, 0);
        step();
        check("stall_v5", out_valid, 1);
        check("stall_d5", out_data, 8'h11);
        check("stall_id5", out_id, 2);
        step();
        check("stall_drain", inflight, 0);

        // Flush with pending request: ptr=3, fill three items
        req = 4'b1111;
        step(); step(); step();
        check("flush_fill", inflight, 3);
        req = 4'b0100; flush = 1'b1;
        settle();
        check("flush_gnt", gnt, 4'b0000);
        step();
        flush = 1'b0;
        check("flush_if", inflight, 0);
        check("flush_v", out_valid, 0);
        settle();
        check("flush_next_gnt", gnt, 4'b0100);
        req = 4'b1111;
        settle();
        check("flush_ptr_kept", gnt, 4'b0100);
        req = 4'b0100;
        step();

        // Reset mid-operation: grant requester 1 so ptr=2, two in flight
        req = 4'b0010;
        settle();
        check("mid_gnt", gnt, 4'b0010);
        step();
        check("mid_if", inflight, 2);
        rst = 1'b1; req = 4'b1111;
        settle();
        check("mid_rst_gnt", gnt, 4'b0000);
        step();
        check("mid_rst_v", out_valid, 0);
        check("mid_rst_if", inflight, 0);
        rst = 1'b0;
        settle();
        check("mid_first_gnt", gnt, 4'b0001);
        step();
        check("mid_after_if", inflight, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
